// File: rtl/clk_gen_pkg.sv
// Shared types for the counter-based multi-channel clock generator.
package clk_gen_pkg;

    localparam int CFG_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        RUN   = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [CFG_CNT_W-1:0] period;
        logic [CFG_CNT_W-1:0] high;
        logic [CFG_CNT_W-1:0] phase;
    } cfg_t;

endpackage

// File: rtl/clk_gen_ch.sv
// One generator channel: shadow/pending config, IDLE/PHASE/RUN FSM, settled tracking.
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = CFG_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] phase_i,
    output logic             pending_o,
    output logic             settled_o,
    output logic             clk_out_o,
    output logic             clk_en_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] sh_phase_q, sh_phase_d;
    logic             pending_q, pending_d;
    logic             settled_q, settled_d;
    logic             clk_out_q, clk_en_q;
    logic             apply;
    logic [CNT_W-1:0] eff_phase;

    // Phase gap never exceeds one period; a disabled period makes this moot.
    assign eff_phase = (sh_phase_q >= sh_period_q) ? sh_period_q - CNT_W'(1) : sh_phase_q;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        high_d      = high_q;
        cnt_d       = cnt_q;
        pcnt_d      = pcnt_q;
        sh_period_d = sh_period_q;
        sh_high_d   = sh_high_q;
        sh_phase_d  = sh_phase_q;
        pending_d   = pending_q;
        settled_d   = settled_q;
        apply       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) apply = 1'b1;
            end
            PHASE: begin
                if (pcnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    pcnt_d = pcnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                // New configs only take over on a period boundary, so no pulse is cut short.
                if (cnt_q == period_q - CNT_W'(1)) begin
                    cnt_d     = '0;
                    settled_d = 1'b1;
                    if (pending_q) apply = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply) begin
            pending_d = 1'b0;
            settled_d = 1'b0;
            period_d  = sh_period_q;
            high_d    = sh_high_q;
            cnt_d     = '0;
            if (sh_period_q < CNT_W'(2)) begin
                state_d = IDLE;
            end else if (eff_phase != '0) begin
                state_d = PHASE;
                pcnt_d  = eff_phase;
            end else begin
                state_d = RUN;
            end
        end

        if (wr_i) begin
            sh_period_d = period_i;
            sh_high_d   = high_i;
            sh_phase_d  = phase_i;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            period_q    <= '0;
            high_q      <= '0;
            cnt_q       <= '0;
            pcnt_q      <= '0;
            sh_period_q <= '0;
            sh_high_q   <= '0;
            sh_phase_q  <= '0;
            pending_q   <= 1'b0;
            settled_q   <= 1'b0;
            clk_out_q   <= 1'b0;
            clk_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            high_q      <= high_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            sh_period_q <= sh_period_d;
            sh_high_q   <= sh_high_d;
            sh_phase_q  <= sh_phase_d;
            pending_q   <= pending_d;
            settled_q   <= settled_d;
            clk_out_q   <= (state_d == RUN) && (cnt_d < high_d);
            clk_en_q    <= (state_d == RUN) && (cnt_d == '0) && (high_d != '0);
        end
    end

    assign pending_o = pending_q;
    assign settled_o = settled_q || ((state_q == IDLE) && !pending_q);
    assign clk_out_o = clk_out_q;
    assign clk_en_o  = clk_en_q;

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock generator top: write decode, ready mux and lock flag.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CFG_CNT_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic              locked
);

    logic [NUM_CH-1:0] pending_w;
    logic [NUM_CH-1:0] settled_w;
    logic [NUM_CH-1:0] wr_w;
    logic              accept_w;
    logic              locked_q, locked_d;

    // Out-of-range channels always look ready so their writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = !pending_w[i];
        end
    end

    assign accept_w = cfg_valid && cfg_ready;

    always_comb begin
        wr_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_w[i] = accept_w && (cfg_ch == CH_W'(i));
        end
    end

    assign locked_d = !accept_w && (&settled_w) && !(|pending_w);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) locked_q <= 1'b0;
        else         locked_q <= locked_d;
    end

    assign locked = locked_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gen_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i    (sys_clk),
            .rst_i    (sys_rst),
            .wr_i     (wr_w[g]),
            .period_i (cfg_period),
            .high_i   (cfg_high),
            .phase_i  (cfg_phase),
            .pending_o(pending_w[g]),
            .settled_o(settled_w[g]),
            .clk_out_o(clk_out[g]),
            .clk_en_o (clk_en[g])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi with hand-computed waveforms.
module tb_clk_gen_multi;
    import clk_gen_pkg::*;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = CFG_CNT_W;
    localparam int CH_W   = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] clk_en;
    logic              locked;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ch0_start;
    int seen;

    logic [2:0] exp_q[$];
    int c_out[17] = '{1,0,0, 1,1,1,0,0,0, 1,1,1,1,0,0,0,0};
    int c_en [17] = '{0,0,0, 1,0,0,0,0,0, 1,0,0,0,0,0,0,0};
    int c_rdy[17] = '{0,0,0, 1,0,0,0,0,0, 1,1,1,1,1,1,1,1};

    clk_gen_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .clk_out   (clk_out),
        .clk_en    (clk_en),
        .locked    (locked)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cfg_t mk(input int p, input int h, input int ph);
        cfg_t c;
        c.period = CNT_W'(p);
        c.high   = CNT_W'(h);
        c.phase  = CNT_W'(ph);
        return c;
    endfunction

    task automatic do_write(input logic [CH_W-1:0] ch, input cfg_t c);
        cfg_ch     = ch;
        cfg_period = c.period;
        cfg_high   = c.high;
        cfg_phase  = c.phase;
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        sys_rst    = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_phase  = '0;
        step();
        step();
        check("rst_out", 32'(clk_out), 0);
        check("rst_en", 32'(clk_en), 0);
        check("rst_lock", 32'(locked), 0);
        check("rst_rdy", 32'(cfg_ready), 1);
        sys_rst = 1'b0;
        step();
        check("idle_lock", 32'(locked), 1);

        // ch0: period 4, high 2, phase 0
        do_write(3'd0, mk(4, 2, 0));
        check("a_lock_lo", 32'(locked), 0);
        check("a_rdy_pend", 32'(cfg_ready), 0);
        check("a_out_t1", 32'(clk_out[0]), 0);
        ch0_start = cyc + 1;
        for (int k = 0; k < 12; k++) begin
            step();
            check("a_out", 32'(clk_out[0]), 32'((k % 4) < 2));
            check("a_en", 32'(clk_en[0]), 32'((k % 4) == 0));
            check("a_lock", 32'(locked), 32'(k >= 5));
        end

        // ch1: period 10, high 2, phase 3
        do_write(3'd1, mk(10, 2, 3));
        check("b_lock_lo", 32'(locked), 0);
        for (int k = 0; k < 24; k++) begin
            step();
            check("b_out", 32'(clk_out[1]), 32'((k >= 3) && (((k - 3) % 10) < 2)));
            check("b_en", 32'(clk_en[1]), 32'((k >= 3) && (((k - 3) % 10) == 0)));
            check("b_lock", 32'(locked), 32'(k >= 14));
            check("b_ch0_out", 32'(clk_out[0]), 32'(((cyc - ch0_start) % 4) < 2));
        end

        // ch0 reconfig mid-run, with a second write stalling behind it
        while (((cyc - ch0_start) % 4) != 0) step();
        do_write(3'd0, mk(6, 3, 0));
        cfg_ch     = 3'd0;
        cfg_period = CNT_W'(8);
        cfg_high   = CNT_W'(4);
        cfg_phase  = CNT_W'(0);
        cfg_valid  = 1'b1;
        for (int j = 0; j < 17; j++) begin
            exp_q.push_back({1'(c_out[j]), 1'(c_en[j]), 1'(c_rdy[j])});
        end
        for (int j = 0; j < 17; j++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check("c_out", 32'(clk_out[0]), 32'(e[2]));
            check("c_en", 32'(clk_en[0]), 32'(e[1]));
            check("c_rdy", 32'(cfg_ready), 32'(e[0]));
            step();
            if (j == 3) cfg_valid = 1'b0;
        end

        // high 0: constant low, no tick
        do_write(3'd2, mk(5, 0, 0));
        for (int k = 0; k < 10; k++) begin
            step();
            check("d_out", 32'(clk_out[2]), 0);
            check("d_en", 32'(clk_en[2]), 0);
        end

        // high >= period and phase >= period: phase clamps to 4, output constant 1
        do_write(3'd3, mk(5, 7, 9));
        for (int k = 0; k < 14; k++) begin
            step();
            check("e_out", 32'(clk_out[3]), 32'(k >= 4));
            check("e_en", 32'(clk_en[3]), 32'((k >= 4) && (((k - 4) % 5) == 0)));
        end

        // period 1 disables ch2; lock must come back
        do_write(3'd2, mk(1, 1, 0));
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (locked) begin
                seen = 1;
                break;
            end
        end
        check("f_lock_recover", 32'(seen), 1);
        check("f_out", 32'(clk_out[2]), 0);
        cfg_ch = 3'd2;
        check("f_rdy", 32'(cfg_ready), 1);

        // write to a non-existent channel: accepted, lock dips one cycle
        cfg_ch     = 3'd5;
        cfg_period = CNT_W'(3);
        cfg_high   = CNT_W'(1);
        cfg_phase  = CNT_W'(0);
        cfg_valid  = 1'b1;
        check("g_rdy_bad", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        check("g_lock_dip", 32'(locked), 0);
        step();
        check("g_lock_back", 32'(locked), 1);
        check("g_ch4_out", 32'(clk_out[4]), 0);

        // asynchronous reset mid-period, then restart with IDLE latency
        cfg_ch = 3'd0;
        check("h_pre_rst", 32'(clk_out[3]), 1);
        #3;
        sys_rst = 1'b1;
        #1;
        check("h_rst_out", 32'(clk_out), 0);
        check("h_rst_en", 32'(clk_en), 0);
        check("h_rst_lock", 32'(locked), 0);
        check("h_rst_rdy", 32'(cfg_ready), 1);
        step();
        sys_rst = 1'b0;
        check("h_rdy_after", 32'(cfg_ready), 1);
        do_write(3'd0, mk(4, 2, 0));
        check("h_out_t1", 32'(clk_out[0]), 0);
        check("h_rdy_pend", 32'(cfg_ready), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("h_out", 32'(clk_out[0]), 32'(k < 2));
            check("h_en", 32'(clk_en[0]), 32'(k == 0));
            check("h_ch3_out", 32'(clk_out[3]), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
